// File: rtl/bcd_updown_counter_7seg.sv
// Multi-digit BCD up/down counter with prescaler, parallel load, wrap pulse and 7-segment decode.
// Optional macro BLANK_LEADING_ZEROS_EN blanks zero digits above the highest nonzero digit.
module bcd_updown_counter_7seg #(
  parameter int NUM_DIGITS = 2,
  parameter int CLK_DIV    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    wrap
);

  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]           presc, presc_nxt;
  logic [4*NUM_DIGITS-1:0] count_nxt;
  logic                    wrap_nxt;
  logic                    step;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1000000;
    endcase
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] hex_of(input logic [4*NUM_DIGITS-1:0] c);
`ifdef BLANK_LEADING_ZEROS_EN
    logic lead;
    lead = 1'b1;
`endif
    hex_of = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef BLANK_LEADING_ZEROS_EN
      if (c[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) hex_of[7*i +: 7] = 7'b1111111;
      else                  hex_of[7*i +: 7] = seg_decode(c[4*i +: 4]);
`else
      hex_of[7*i +: 7] = seg_decode(c[4*i +: 4]);
`endif
    end
  endfunction

  // Illegal load digits (>9) collapse to 0 so the count stays valid BCD.
  function automatic logic [4*NUM_DIGITS-1:0] sanitize(input logic [4*NUM_DIGITS-1:0] v);
    sanitize = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      sanitize[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
  endfunction

  // Ripple carry/borrow across digits; the MSB of the result is the wrap flag.
  function automatic logic [4*NUM_DIGITS:0] bump(input logic [4*NUM_DIGITS-1:0] c,
                                                  input logic up);
    logic [4*NUM_DIGITS-1:0] res;
    logic                    carry;
    logic [3:0]              d;
    res   = c;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = c[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d == 4'd9) res[4*i +: 4] = 4'd0;
          else begin
            res[4*i +: 4] = 4'(d + 4'd1);
            carry         = 1'b0;
          end
        end else begin
          if (d == 4'd0) res[4*i +: 4] = 4'd9;
          else begin
            res[4*i +: 4] = 4'(d - 4'd1);
            carry         = 1'b0;
          end
        end
      end
    end
    bump = {carry, res};
  endfunction

  always_comb begin
    step      = enable && (presc == PRE_LAST);
    presc_nxt = presc;
    count_nxt = count_bcd;
    wrap_nxt  = 1'b0;
    if (load) begin
      count_nxt = sanitize(load_val);
      presc_nxt = '0;
    end else if (enable) begin
      if (step) begin
        presc_nxt             = '0;
        {wrap_nxt, count_nxt} = bump(count_bcd, up_down);
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end
  end

  // Output register: hex is decoded from the next count so it never lags count_bcd.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_bcd <= '0;
      presc     <= '0;
      wrap      <= 1'b0;
      hex       <= hex_of('0);
    end else begin
      count_bcd <= count_nxt;
      presc     <= presc_nxt;
      wrap      <= wrap_nxt;
      hex       <= hex_of(count_nxt);
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// Randomized bench for bcd_updown_counter_7seg: integer reference model plus literal spot checks.
// Two instances: 2 digits / CLK_DIV=1 and 3 digits / CLK_DIV=4, sharing control inputs.
module tb_bcd_updown_counter_7seg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  lv1 = '0;
  logic [11:0] lv2 = '0;
  logic [7:0]  count1;
  logic [11:0] count2;
  logic [13:0] hex1;
  logic [20:0] hex2;
  logic        wrap1, wrap2;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  int m_cnt [2];
  int m_pre [2];
  bit m_wrap [2];

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  bcd_updown_counter_7seg #(.NUM_DIGITS(2), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_val(lv1), .count_bcd(count1), .hex(hex1), .wrap(wrap1));

  bcd_updown_counter_7seg #(.NUM_DIGITS(3), .CLK_DIV(4)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_val(lv2), .count_bcd(count2), .hex(hex2), .wrap(wrap2));

  function automatic int pow10(input int e);
    pow10 = 1;
    for (int i = 0; i < e; i++) pow10 = pow10 * 10;
  endfunction

  function automatic logic [23:0] exp_bcd(input int v, input int n);
    exp_bcd = '0;
    for (int i = 0; i < n; i++) exp_bcd[4*i +: 4] = 4'((v / pow10(i)) % 10);
  endfunction

  function automatic logic [41:0] exp_hex(input int v, input int n);
    int hi;
    int d;
    hi = 0;
    for (int i = 0; i < n; i++) if (((v / pow10(i)) % 10) != 0) hi = i;
    exp_hex = '0;
    for (int i = 0; i < n; i++) begin
      d = (v / pow10(i)) % 10;
`ifdef BLANK_LEADING_ZEROS_EN
      exp_hex[7*i +: 7] = (i > hi) ? 7'b1111111 : segtab[d];
`else
      exp_hex[7*i +: 7] = segtab[d];
`endif
    end
  endfunction

  function automatic int load_int(input logic [23:0] lv, input int n);
    int nib;
    load_int = 0;
    for (int i = 0; i < n; i++) begin
      nib = int'(lv[4*i +: 4]);
      load_int += ((nib > 9) ? 0 : nib) * pow10(i);
    end
  endfunction

  task automatic model_step(input int k, input int n, input int div, input logic [23:0] lv);
    int maxv;
    maxv = pow10(n) - 1;
    m_wrap[k] = 1'b0;
    if (reset) begin
      m_cnt[k] = 0;
      m_pre[k] = 0;
    end else if (load) begin
      m_cnt[k] = load_int(lv, n);
      m_pre[k] = 0;
    end else if (enable) begin
      if (m_pre[k] == div - 1) begin
        m_pre[k] = 0;
        if (up_down) begin
          if (m_cnt[k] == maxv) begin m_cnt[k] = 0; m_wrap[k] = 1'b1; end
          else m_cnt[k] = m_cnt[k] + 1;
        end else begin
          if (m_cnt[k] == 0) begin m_cnt[k] = maxv; m_wrap[k] = 1'b1; end
          else m_cnt[k] = m_cnt[k] - 1;
        end
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 2, 1, {16'h0, lv1});
    model_step(1, 3, 4, {12'h0, lv2});
  end

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("count1", 42'(count1), 42'(exp_bcd(m_cnt[0], 2)));
      chk("hex1",   42'(hex1),   exp_hex(m_cnt[0], 2));
      chk("wrap1",  42'(wrap1),  42'(m_wrap[0]));
      chk("count2", 42'(count2), 42'(exp_bcd(m_cnt[1], 3)));
      chk("hex2",   42'(hex2),   exp_hex(m_cnt[1], 3));
      chk("wrap2",  42'(wrap2),  42'(m_wrap[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    armed = 1'b1;
    chk("rst_count1", 42'(count1), 42'h0);
    chk("rst_wrap1", 42'(wrap1), 42'h0);
`ifdef BLANK_LEADING_ZEROS_EN
    chk("rst_hex1", 42'(hex1), 42'({7'b1111111, 7'b1000000}));
`else
    chk("rst_hex1", 42'(hex1), 42'({7'b1000000, 7'b1000000}));
`endif
    reset = 1'b0;

    // count up 10 steps from 00
    enable = 1'b1; up_down = 1'b1;
    repeat (10) tick();
    chk("up10_count1", 42'(count1), 42'h10);
    chk("up10_hex1_d1", 42'(hex1[13:7]), 42'(7'b1111001));
    chk("up10_count2_div4", 42'(count2), 42'h002);

    // load 99 then wrap up
    load = 1'b1; lv1 = 8'h99; lv2 = 12'h999;
    tick();
    load = 1'b0;
    chk("load99", 42'(count1), 42'h99);
    tick();
    chk("wrapup_count", 42'(count1), 42'h00);
    chk("wrapup_pulse", 42'(wrap1), 42'h1);
    tick();
    chk("wrapup_pulse_end", 42'(wrap1), 42'h0);

    // load 00 then wrap down
    load = 1'b1; lv1 = 8'h00; lv2 = 12'h050;
    tick();
    load = 1'b0; up_down = 1'b0;
    tick();
    chk("wrapdn_count", 42'(count1), 42'h99);
    chk("wrapdn_pulse", 42'(wrap1), 42'h1);
    tick();
    chk("dn_count", 42'(count1), 42'h98);
    chk("dn_wrap_low", 42'(wrap1), 42'h0);

    // prescaler hold while enable low (dut2)
    load = 1'b1; lv2 = 12'h050; up_down = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    enable = 1'b0;
    repeat (3) tick();
    chk("hold_count2", 42'(count2), 42'h050);
    enable = 1'b1;
    tick();
    chk("pre_count2", 42'(count2), 42'h050);
    tick();
    chk("step_count2", 42'(count2), 42'h051);

    // load beats step; illegal digit becomes 0; reset beats load
    load = 1'b1; lv1 = 8'h3A; lv2 = 12'h005;
    tick();
    chk("load_3A", 42'(count1), 42'h30);
`ifdef BLANK_LEADING_ZEROS_EN
    chk("hex2_005", 42'(hex2), 42'({7'b1111111, 7'b1111111, 7'b0010010}));
`else
    chk("hex2_005", 42'(hex2), 42'({7'b1000000, 7'b1000000, 7'b0010010}));
`endif
    lv2 = 12'h100;
    tick();
    chk("hex2_100", 42'(hex2), 42'({7'b1111001, 7'b1000000, 7'b1000000}));
    reset = 1'b1;
    tick();
    chk("rst_over_load", 42'(count1), 42'h00);
    reset = 1'b0; load = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(99) == 0);
      load   = ($urandom_range(24) == 0);
      enable = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) up_down = ~up_down;
      lv1 = 8'($urandom);
      lv2 = 12'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
